// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant bundle between the bus-request stages and one bus_arbiter.
//   req          requester -> arbiter, one level-sensitive bit per requester
//   grant        arbiter -> requester, one-hot-or-zero, registered
//   owner        arbiter -> requester, index of grant holder (valid when busy)
//   busy         arbiter -> requester, high while any grant bit is high
//   timeout_evt  arbiter -> requester, one-cycle pulse on a timeout revoke
// Modports: master = arbiter side, slave = requester side.
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int OWNER_W = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [OWNER_W-1:0] owner;
  logic               busy;
  logic               timeout_evt;

  modport master (
    input  req,
    output grant,
    output owner,
    output busy,
    output timeout_evt
  );

  modport slave (
    output req,
    input  grant,
    input  owner,
    input  busy,
    input  timeout_evt
  );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for one shared register bus (read or write bus).
// Requester 0 = Firewire, 1 = Ethernet, 2 = PS EMIO. Ownership is held until
// the owner drops its request or, while someone else waits, until TIMEOUT
// grant cycles have elapsed. Every change of owner passes through one idle
// gap cycle so the old owner sees its grant drop before a new owner drives.
// Ports:
//   sysclk  system clock, rising edge
//   reset   asynchronous, active-low reset
//   arb     bus_arbiter_if.master (req in; grant/owner/busy/timeout_evt out)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int          NUM_REQ = 3,
  parameter int          OWNER_W = 2,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input logic           sysclk,
  input logic           reset,
  bus_arbiter_if.master arb
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // After reset the search starts just past the top index, so index 0 wins first.
  localparam logic [OWNER_W-1:0] LAST_INIT = OWNER_W'(NUM_REQ - 1);

  state_t             state_r;
  logic [15:0]        hold_cnt_r;
  logic [OWNER_W-1:0] last_owner_r;
  logic [OWNER_W-1:0] owner_r;
  logic [NUM_REQ-1:0] grant_r;
  logic               busy_r;
  logic               timeout_evt_r;

  logic               win_valid_s;
  logic [OWNER_W-1:0] win_idx_s;
  logic [NUM_REQ-1:0] owner_mask_s;
  logic               owner_req_s;
  logic               contender_s;
  logic               timeout_hit_s;

  // One-hot decode; indices >= NUM_REQ decode to all zeros.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [OWNER_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      vec[k] = (idx == OWNER_W'(k));
    end
    return vec;
  endfunction

  // Round-robin winner: smallest distance past last_owner among active requests.
  always_comb begin : winner_search
    int dist_s;
    int best_s;
    win_valid_s = 1'b0;
    win_idx_s   = '0;
    dist_s      = 0;
    best_s      = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      dist_s = (j + NUM_REQ - 1 - int'(last_owner_r)) % NUM_REQ;
      if (arb.req[j] && (dist_s < best_s)) begin
        best_s      = dist_s;
        win_idx_s   = OWNER_W'(j);
        win_valid_s = 1'b1;
      end else begin
        best_s = best_s;
      end
    end
  end

  // Owner release / contender / timeout qualifiers for the ST_GRANT decision.
  always_comb begin
    owner_mask_s  = onehot(owner_r);
    owner_req_s   = |(arb.req & owner_mask_s);
    contender_s   = |(arb.req & ~owner_mask_s);
    if ((TIMEOUT != 16'd0) && (hold_cnt_r == (TIMEOUT - 16'd1)) && contender_s) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Arbitration FSM with registered grant/owner/busy/timeout_evt.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      hold_cnt_r    <= 16'd0;
      last_owner_r  <= LAST_INIT;
      owner_r       <= '0;
      grant_r       <= '0;
      busy_r        <= 1'b0;
      timeout_evt_r <= 1'b0;
    end else begin
      timeout_evt_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_GAP: begin
          // The gap arbitrates exactly like idle; it only exists to force
          // one grant-free cycle between owners.
          if (win_valid_s) begin
            grant_r      <= onehot(win_idx_s);
            busy_r       <= 1'b1;
            owner_r      <= win_idx_s;
            last_owner_r <= win_idx_s;
            hold_cnt_r   <= 16'd0;
            state_r      <= ST_GRANT;
          end else begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (hold_cnt_r != 16'hFFFF) begin
            hold_cnt_r <= hold_cnt_r + 16'd1;
          end
          // Release takes precedence, so a simultaneous timeout is silent.
          if (!owner_req_s) begin
            grant_r <= '0;
            busy_r  <= 1'b0;
            state_r <= ST_GAP;
          end else if (timeout_hit_s) begin
            grant_r       <= '0;
            busy_r        <= 1'b0;
            timeout_evt_r <= 1'b1;
            state_r       <= ST_GAP;
          end else begin
            state_r <= ST_GRANT;
          end
        end
        default: begin
          grant_r <= '0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb.grant       = grant_r;
  assign arb.owner       = owner_r;
  assign arb.busy        = busy_r;
  assign arb.timeout_evt = timeout_evt_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed, table-driven bench for bus_arbiter (NUM_REQ=3, TIMEOUT=8).
// Each table record is one clock: req applied before the edge, expected
// grant/owner/busy/timeout_evt sampled 1 ns after the edge. Async reset and
// the long no-contender hold are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  typedef struct {
    logic [2:0] req;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       tevt;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  vec_t tbl[$];

  bus_arbiter_if #(.NUM_REQ(3), .OWNER_W(2)) bif ();

  bus_arbiter #(
    .NUM_REQ(3),
    .OWNER_W(2),
    .TIMEOUT(16'd8)
  ) dut (
    .sysclk(clk),
    .reset (rst),
    .arb   (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [2:0] r, input logic [2:0] g, input logic [1:0] o,
                     input logic b, input logic t);
    vec_t v;
    v.req = r; v.grant = g; v.owner = o; v.busy = b; v.tevt = t;
    tbl.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [2:0] r, input logic [2:0] g,
                       input logic [1:0] o, input logic b);
    for (int k = 0; k < n; k++) add(r, g, o, b, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0;
    bif.req = 3'b000;

    // Single requester: 100 for 5 edges, dropped at edge 5, then idle.
    add_n(5, 3'b100, 3'b100, 2'd2, 1'b1);
    add_n(3, 3'b000, 3'b000, 2'd0, 1'b0);
    // Simultaneous: each owner keeps grant 3 cycles, one zero cycle between.
    add_n(3, 3'b111, 3'b001, 2'd0, 1'b1);
    add  (   3'b110, 3'b000, 2'd0, 1'b0, 1'b0);
    add_n(3, 3'b110, 3'b010, 2'd1, 1'b1);
    add  (   3'b100, 3'b000, 2'd0, 1'b0, 1'b0);
    add_n(3, 3'b100, 3'b100, 2'd2, 1'b1);
    add_n(2, 3'b000, 3'b000, 2'd0, 1'b0);
    // Fairness: 1 owns with 0 and 2 pending; after 1 releases 2 wins, then 0.
    add  (   3'b010, 3'b010, 2'd1, 1'b1, 1'b0);
    add  (   3'b111, 3'b010, 2'd1, 1'b1, 1'b0);
    add  (   3'b101, 3'b000, 2'd0, 1'b0, 1'b0);
    add  (   3'b101, 3'b100, 2'd2, 1'b1, 1'b0);
    add  (   3'b001, 3'b000, 2'd0, 1'b0, 1'b0);
    add  (   3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
    add_n(2, 3'b000, 3'b000, 2'd0, 1'b0);
    // Timeout: req[0] alone 2 cycles, then contender; 8 grant cycles, gap, 010.
    add_n(2, 3'b001, 3'b001, 2'd0, 1'b1);
    add_n(6, 3'b011, 3'b001, 2'd0, 1'b1);
    add  (   3'b011, 3'b000, 2'd0, 1'b0, 1'b1);
    add  (   3'b011, 3'b010, 2'd1, 1'b1, 1'b0);
    add_n(2, 3'b000, 3'b000, 2'd0, 1'b0);
    // Release on the timeout edge: counts as release, no timeout_evt.
    add  (   3'b100, 3'b100, 2'd2, 1'b1, 1'b0);
    add_n(7, 3'b101, 3'b100, 2'd2, 1'b1);
    add  (   3'b001, 3'b000, 2'd0, 1'b0, 1'b0);
    add  (   3'b001, 3'b001, 2'd0, 1'b1, 1'b0);
    add_n(2, 3'b000, 3'b000, 2'd0, 1'b0);

    // Reset state.
    #12;
    check("reset_grant", 32'(bif.grant), 32'd0);
    check("reset_busy",  32'(bif.busy),  32'd0);
    check("reset_owner", 32'(bif.owner), 32'd0);
    check("reset_tevt",  32'(bif.timeout_evt), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      bif.req = tbl[i].req;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_grant", i), 32'(bif.grant), 32'(tbl[i].grant));
      check($sformatf("v%0d_busy", i),  32'(bif.busy),  32'(tbl[i].busy));
      check($sformatf("v%0d_tevt", i),  32'(bif.timeout_evt), 32'(tbl[i].tevt));
      if (tbl[i].busy) begin
        check($sformatf("v%0d_owner", i), 32'(bif.owner), 32'(tbl[i].owner));
      end
    end

    // Reset mid-grant: index 0 owns (last_owner=0), async reset between edges.
    begin
      int waited;
      waited = 0;
      bif.req = 3'b001;
      @(posedge clk);
      #1;
      while (bif.grant !== 3'b001 && waited < 5) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check("rst_mid_pre_grant", 32'(bif.grant), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_grant", 32'(bif.grant), 32'd0);
      check("rst_mid_busy",  32'(bif.busy),  32'd0);
      check("rst_mid_tevt",  32'(bif.timeout_evt), 32'd0);
      // With 1 and 0 both requesting, restored last_owner makes 0 win again.
      bif.req = 3'b011;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_regrant", 32'(bif.grant), 32'd1);
      check("rst_mid_owner",   32'(bif.owner), 32'd0);
    end

    // No contender: req[0] held 2000 cycles, never revoked.
    begin
      int bad_g;
      int bad_t;
      bad_g = 0;
      bad_t = 0;
      bif.req = 3'b001;
      for (int c = 0; c < 2000; c++) begin
        @(posedge clk);
        #1;
        if (bif.grant !== 3'b001) bad_g++;
        if (bif.timeout_evt !== 1'b0) bad_t++;
      end
      check("hold_alone_grant_drops", 32'(bad_g), 32'd0);
      check("hold_alone_tevt_pulses", 32'(bad_t), 32'd0);
      check("hold_alone_grant_end",   32'(bif.grant), 32'd1);
    end

    bif.req = 3'b000;
    @(posedge clk);
    #1;
    check("final_gap", 32'(bif.grant), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
